// File: rtl/inst_fetch.sv
// Instruction-fetch reader: issues one bus read per PC over req/gnt/rvalid and
// hands each fetched word to decode through a valid/ready output slot.
module inst_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned       TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              jump_flag,
    output logic              hold_pc,
    output logic              ibus_req,
    output logic [ADDR_W-1:0] ibus_addr,
    input  logic              ibus_gnt,
    input  logic              ibus_rvalid,
    input  logic [DATA_W-1:0] ibus_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              fetch_err,
    output logic [1:0]        dbg_state
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Handshake: a request is accepted in any cycle with ibus_req & ibus_gnt;
    // ibus_req/ibus_addr never change until then. A word moves to decode in
    // any cycle with inst_valid & inst_ready; inst_out/inst_addr never change
    // while inst_valid & !inst_ready.

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt;
    logic              discard;
    logic              armed;

    logic              slot_free;
    logic              issue;
    logic              accept;
    logic              timeout_hit;
    logic [ADDR_W-1:0] pc_aligned;
    logic              unused_pc_bits;

    assign pc_aligned     = {pc_in[ADDR_W-1:2], 2'b00};
    assign unused_pc_bits = ^pc_in[1:0];
    assign slot_free      = !inst_valid || inst_ready;

    // armed is low for the first cycle after reset release, so nothing is
    // requested (and no stray response is consumed) in that cycle.
    assign issue       = (state == IDLE) && armed && slot_free && !jump_flag;
    assign ibus_req    = issue || (state == REQ);
    assign ibus_addr   = issue ? pc_aligned : addr_q;
    assign accept      = (state == WAIT) && ibus_rvalid && !discard && !jump_flag;
    assign timeout_hit = (state == WAIT) && !ibus_rvalid && (cnt == CNT_W'(TIMEOUT - 1));
    assign hold_pc     = !(jump_flag || accept);
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            cnt        <= '0;
            discard    <= 1'b0;
            armed      <= 1'b0;
            inst_valid <= 1'b0;
            inst_out   <= NOP_INST;
            inst_addr  <= '0;
            fetch_err  <= 1'b0;
        end else begin
            armed     <= 1'b1;
            fetch_err <= 1'b0;
            if (inst_valid && inst_ready) begin
                inst_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (issue) begin
                        addr_q <= pc_aligned;
                        cnt    <= '0;
                        state  <= ibus_gnt ? WAIT : REQ;
                    end
                end
                REQ: begin
                    if (ibus_gnt) begin
                        cnt   <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (ibus_rvalid) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                        if (accept) begin
                            inst_valid <= 1'b1;
                            inst_out   <= ibus_rdata;
                            inst_addr  <= addr_q;
                        end
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        fetch_err <= 1'b1;
                        discard   <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            // A jump flushes the slot and poisons whatever response is still owed.
            if (jump_flag) begin
                inst_valid <= 1'b0;
                inst_out   <= NOP_INST;
                if ((state == REQ) || ((state == WAIT) && !ibus_rvalid && !timeout_hit)) begin
                    discard <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a PC register + bus responder environment, a program-order
// scoreboard for the decode stream, and directed plus randomized scenarios.
module tb_inst_fetch;

    localparam int          AW  = 32;
    localparam int          DW  = 32;
    localparam int          TO  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic          jump_flag = 1'b0;
    logic          hold_pc;
    logic          ibus_req;
    logic [AW-1:0] ibus_addr;
    logic          ibus_gnt = 1'b0;
    logic          ibus_rvalid = 1'b0;
    logic [DW-1:0] ibus_rdata = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [DW-1:0] inst_out;
    logic [AW-1:0] inst_addr;
    logic          fetch_err;
    logic [1:0]    dbg_state;

    inst_fetch #(.ADDR_W(AW), .DATA_W(DW), .NOP_INST(NOP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .jump_flag(jump_flag), .hold_pc(hold_pc),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_gnt(ibus_gnt),
        .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_out(inst_out), .inst_addr(inst_addr),
        .fetch_err(fetch_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] salt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    // environment / reference model state
    logic [31:0] pc_model = '0, exp_pc = '0;
    logic [63:0] exp_q[$];
    bit          outstanding, stale, exp_err, exp_load, prev_pend, prev_flush, prev_hold_word;
    logic [31:0] out_addr, prev_addr, held_out, held_addr, ld_addr;
    int          out_age, out_lat, req_age, gnt_lat_cur, cyc;

    // knobs driven by the scenario tasks
    bit          rand_mode, ready_drv, jump_drv, force_rv;
    logic [31:0] jump_tgt;
    int          gnt_lat_cfg = 0, rv_lat_cfg = 1;

    // what the last step observed
    bit          obs_req, obs_gnt, obs_new, obs_valid, obs_err, obs_hold, consumed;
    logic [31:0] obs_addr, obs_out, consumed_addr;

    task automatic clear_model();
        outstanding = 0; stale = 0; exp_err = 0; exp_load = 0;
        prev_pend = 0; prev_flush = 0; prev_hold_word = 0; req_age = 0;
        exp_q.delete();
        exp_pc = {pc_model[31:2], 2'b00};
    endtask

    // One clock cycle: drive at the falling edge, sample 2ns later, then
    // advance the environment and reference model across the rising edge.
    task automatic step();
        logic [63:0] e;
        logic [31:0] expa;
        bit rv, tmo, exp_hold, was_out;
        if (rand_mode) begin
            ready_drv = ($urandom_range(0, 3) != 0);
            jump_drv  = ($urandom_range(0, 24) == 0);
            jump_tgt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
        end
        rv = outstanding && (out_lat != 0) && (out_age == out_lat);
        jump_flag   = jump_drv;
        inst_ready  = ready_drv;
        pc_in       = pc_model;
        ibus_rvalid = rv || force_rv;
        ibus_rdata  = rv ? mem_word(out_addr) : $urandom();
        if (req_age == 0) gnt_lat_cur = rand_mode ? $urandom_range(0, 3) : gnt_lat_cfg;
        #1;
        ibus_gnt = ibus_req && (req_age >= gnt_lat_cur);
        #1;
        obs_req = ibus_req; obs_gnt = ibus_gnt; obs_addr = ibus_addr; obs_hold = hold_pc;
        obs_valid = inst_valid; obs_out = inst_out; obs_err = fetch_err;
        obs_new = ibus_req && !prev_pend;

        exp_hold = !(jump_drv || (rv && !stale));
        checks++;
        if (hold_pc !== exp_hold) begin
            errors++; $display("FAIL hold_pc cyc %0d: got %b expected %b", cyc, hold_pc, exp_hold);
        end
        if (prev_pend) begin
            checks++;
            if (ibus_req !== 1'b1 || ibus_addr !== prev_addr) begin
                errors++; $display("FAIL req_stable cyc %0d: got req %b addr %h expected req 1 addr %h", cyc, ibus_req, ibus_addr, prev_addr);
            end
        end else if (ibus_req === 1'b1) begin
            expa = {pc_model[31:2], 2'b00};
            checks++;
            if (outstanding || jump_drv || ibus_addr !== expa || (inst_valid === 1'b1 && !ready_drv)) begin
                errors++; $display("FAIL new_req cyc %0d: got addr %h (outst %b jump %b valid %b ready %b) expected addr %h, slot free, none outstanding", cyc, ibus_addr, outstanding, jump_drv, inst_valid, ready_drv, expa);
            end
        end
        checks++;
        if (fetch_err !== exp_err) begin
            errors++; $display("FAIL fetch_err cyc %0d: got %b expected %b", cyc, fetch_err, exp_err);
        end
        if (prev_flush) begin
            checks++;
            if (inst_valid !== 1'b0 || inst_out !== NOP) begin
                errors++; $display("FAIL flush cyc %0d: got valid %b out %h expected 0 %h", cyc, inst_valid, inst_out, NOP);
            end
        end
        if (exp_load) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_addr !== ld_addr || inst_out !== mem_word(ld_addr)) begin
                errors++; $display("FAIL load cyc %0d: got %b %h %h expected 1 %h %h", cyc, inst_valid, inst_addr, inst_out, ld_addr, mem_word(ld_addr));
            end
        end
        if (prev_hold_word) begin
            checks++;
            if (inst_valid !== 1'b1 || inst_out !== held_out || inst_addr !== held_addr) begin
                errors++; $display("FAIL stall_hold cyc %0d: got %b %h %h expected 1 %h %h", cyc, inst_valid, inst_addr, inst_out, held_addr, held_out);
            end
        end
        consumed = (inst_valid === 1'b1) && ready_drv && !jump_drv;
        if (consumed) begin
            if (exp_q.size() == 0) begin
                exp_q.push_back({exp_pc, mem_word(exp_pc)});
                exp_pc = exp_pc + 32'd4;
            end
            e = exp_q.pop_front();
            consumed_addr = inst_addr;
            checks++;
            if ({inst_addr, inst_out} !== e) begin
                errors++; $display("FAIL stream cyc %0d: got addr %h data %h expected addr %h data %h", cyc, inst_addr, inst_out, e[63:32], e[31:0]);
            end
        end

        // advance the model across the rising edge
        prev_pend      = ibus_req && !ibus_gnt;
        prev_addr      = ibus_addr;
        prev_flush     = jump_drv;
        prev_hold_word = (inst_valid === 1'b1) && !ready_drv && !jump_drv;
        held_out = inst_out; held_addr = inst_addr;
        exp_load = rv && !stale && !jump_drv;
        ld_addr  = out_addr;
        was_out  = outstanding;
        tmo      = outstanding && !rv && (out_age >= TO);
        exp_err  = tmo;
        if (rv || tmo) begin
            outstanding = 0; stale = 0;
        end else if (outstanding) begin
            out_age++;
        end
        if (jump_drv && (ibus_req === 1'b1 || (was_out && !rv && !tmo))) stale = 1;
        if (ibus_req === 1'b1 && ibus_gnt) begin
            outstanding = 1; out_addr = ibus_addr; out_age = 1; req_age = 0;
            out_lat = rand_mode ? $urandom_range(1, TO) : rv_lat_cfg;
        end else if (ibus_req === 1'b1) begin
            req_age++;
        end
        if (jump_drv) begin
            pc_model = jump_tgt;
            exp_q.delete();
            exp_pc = {jump_tgt[31:2], 2'b00};
        end else if (hold_pc === 1'b0) begin
            pc_model = pc_model + 32'd4;
        end
        if (!rand_mode) jump_drv = 0;
        force_rv = 0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; pc_model = 32'h0; clear_model();
        @(negedge clk); @(negedge clk);
        checks++;
        if ({ibus_req, ibus_addr, inst_valid, inst_out, inst_addr, hold_pc, fetch_err, dbg_state} !==
            {1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b1, 1'b0, 2'd0}) begin
            errors++; $display("FAIL reset_values: got req %b addr %h valid %b out %h iaddr %h hold %b err %b st %0d", ibus_req, ibus_addr, inst_valid, inst_out, inst_addr, hold_pc, fetch_err, dbg_state);
        end
        rst_n = 1; ready_drv = 1;
        step();
        checks++;
        if (obs_req !== 1'b0) begin
            errors++; $display("FAIL first_cycle_req: got %b expected 0", obs_req);
        end
    endtask

    task automatic test_zero_wait();
        int n = 0;
        int cy[3];
        logic [31:0] ad[3];
        gnt_lat_cfg = 0; rv_lat_cfg = 1; ready_drv = 1;
        for (int i = 0; i < 20 && n < 3; i++) begin
            step();
            if (consumed) begin cy[n] = cyc; ad[n] = consumed_addr; n++; end
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL zero_wait_count: got %0d words expected 3", n);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ad[k] !== 32'(4 * k)) begin
                    errors++; $display("FAIL zero_wait_addr%0d: got %h expected %h", k, ad[k], 32'(4 * k));
                end
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (cy[k] - cy[k-1] != 2) begin
                    errors++; $display("FAIL zero_wait_rate: got %0d cycles expected 2", cy[k] - cy[k-1]);
                end
            end
        end
    endtask

    task automatic test_gnt_delay();
        int n = 0, holds = 0;
        bit started = 0, done = 0;
        gnt_lat_cfg = 3; ready_drv = 1;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (!started && obs_new) started = 1;
            if (started && obs_req) begin
                n++;
                if (!obs_hold) holds++;
                if (obs_gnt) done = 1;
            end
        end
        checks++;
        if (!done || n != 4 || holds != 0) begin
            errors++; $display("FAIL gnt_delay: got %0d req cycles, %0d hold_pc lows, granted %b expected 4, 0, 1", n, holds, done);
        end
        gnt_lat_cfg = 0;
    endtask

    task automatic test_ready_stall();
        int reqs = 0;
        bit got = 0, cons = 0;
        logic [31:0] w, a;
        ready_drv = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (obs_valid) got = 1;
        end
        w = obs_out; a = inst_addr;
        for (int i = 0; i < 5; i++) begin
            step();
            if (obs_req) reqs++;
        end
        checks++;
        if (!got || reqs != 0 || inst_out !== w) begin
            errors++; $display("FAIL ready_stall: got valid %b reqs %0d out %h expected 1 0 %h", got, reqs, inst_out, w);
        end
        ready_drv = 1;
        step();
        cons = consumed;
        checks++;
        if (!cons || !obs_req || obs_addr !== a + 32'd4) begin
            errors++; $display("FAIL ready_resume: got consumed %b req %b addr %h expected 1 1 %h", cons, obs_req, obs_addr, a + 32'd4);
        end
    endtask

    task automatic test_jump_wait();
        bit found = 0, leaked = 0;
        rv_lat_cfg = 3; ready_drv = 1;
        for (int i = 0; i < 20 && !outstanding; i++) step();
        jump_drv = 1; jump_tgt = 32'h100;
        step();
        rv_lat_cfg = 1;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (obs_new) found = 1;
            else if (obs_valid) leaked = 1;
        end
        checks++;
        if (!found || leaked || obs_addr !== 32'h100) begin
            errors++; $display("FAIL jump_wait: got req %b leaked %b addr %h expected 1 0 00000100", found, leaked, obs_addr);
        end
    endtask

    task automatic test_timeout();
        bit granted = 0, seen = 0;
        int n = 0;
        logic [31:0] a;
        rv_lat_cfg = 0; ready_drv = 1;
        for (int i = 0; i < 30 && !granted; i++) begin
            step();
            if (obs_req && obs_gnt) begin granted = 1; a = obs_addr; end
        end
        rv_lat_cfg = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(); n++;
            if (obs_err) seen = 1;
        end
        checks++;
        if (!granted || !seen || n != TO + 1 || !obs_new || obs_addr !== a) begin
            errors++; $display("FAIL timeout: got err %b after %0d cycles rereq %b addr %h expected 1 after %0d, 1, %h", seen, n, obs_new, obs_addr, TO + 1, a);
        end
        step();
        checks++;
        if (obs_err !== 1'b0) begin
            errors++; $display("FAIL err_pulse: got %b expected 0", obs_err);
        end
    endtask

    task automatic test_reset_mid();
        rv_lat_cfg = 3; ready_drv = 1;
        for (int i = 0; i < 20 && !outstanding; i++) step();
        step();
        rst_n = 0;
        #1;
        checks++;
        if ({ibus_req, ibus_addr, inst_valid, inst_out, inst_addr, hold_pc, fetch_err, dbg_state} !==
            {1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b1, 1'b0, 2'd0}) begin
            errors++; $display("FAIL reset_mid: got req %b addr %h valid %b out %h iaddr %h hold %b err %b st %0d", ibus_req, ibus_addr, inst_valid, inst_out, inst_addr, hold_pc, fetch_err, dbg_state);
        end
        @(negedge clk);
        clear_model(); rv_lat_cfg = 1;
        rst_n = 1; force_rv = 1;
        step();
        step();
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++; $display("FAIL late_rvalid: got valid %b expected 0", obs_valid);
        end
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic test_random();
        int words = 0;
        rand_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (consumed) words++;
        end
        rand_mode = 0; jump_drv = 0; ready_drv = 1;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (words < 100) begin
            errors++; $display("FAIL random_progress: got %0d words expected at least 100", words);
        end
    endtask

    initial begin
        salt = $urandom();
        @(negedge clk);
        test_reset();
        test_zero_wait();
        test_gnt_delay();
        test_ready_stall();
        test_jump_wait();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within 200000ns");
        $fatal(1, "watchdog");
    end

endmodule
